// File: rtl/sti_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sti_pkg
// Description : Shared definitions for the serial-to-word receiver.
//               Frame length codes, the length-code-to-bit-count mapping,
//               word/FIFO widths and the receiver FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sti_pkg;

  // Frame length codes carried on cfg_length / po_len
  localparam logic [1:0] LEN_8  = 2'd0;
  localparam logic [1:0] LEN_16 = 2'd1;
  localparam logic [1:0] LEN_24 = 2'd2;
  localparam logic [1:0] LEN_32 = 2'd3;

  localparam int WORD_W = 32;
  localparam int LEN_W  = 2;
  localparam int FIFO_W = WORD_W + LEN_W;  // {len, data}

  // Receiver FSM states (explicit 1-bit encoding)
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_t;

  // Number of bits N in a frame for a given length code: N = 8*(code+1)
  function automatic logic [5:0] len_bits(input logic [1:0] code);
    logic [5:0] n;
    case (code)
      LEN_8:   n = 6'd8;
      LEN_16:  n = 6'd16;
      LEN_24:  n = 6'd24;
      LEN_32:  n = 6'd32;
      default: n = 6'd8;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sti_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sti_rx_fifo
// Description : Synchronous FIFO buffering assembled {len, data} words.
//               A push while full is dropped unless a pop happens in the
//               same cycle, which frees the slot being written.
// Ports       : clk, reset      - clock, asynchronous active-high reset
//               push, push_data - write request and word
//               pop             - read request (ignored when empty)
//               pop_data        - word at the head of the FIFO
//               full, empty     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module sti_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra wrap bit to tell full from empty
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign pop_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the read side is qualified by empty
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/sti_rx.sv
`default_nettype none
// ============================================================================
// Module      : sti_rx
// Description : Serial receiver. Assembles 8/16/24/32-bit frames from a
//               bit-serial stream (MSB- or LSB-first), buffers completed
//               words in a FIFO and presents them on a valid/ready port.
// Ports       : clk, reset              - clock, async active-high reset
//               si_data, si_valid       - serial bit and bit strobe
//               cfg_length, cfg_msb     - frame format, taken on first bit
//               si_end                  - final-frame marker, on last bit
//               po_data, po_len         - head word and its length code
//               po_valid, po_ready      - output handshake
//               frame_err               - pulse on truncated frame
//               overflow                - pulse on word dropped (FIFO full)
//               rx_finish               - sticky end-of-reception flag
// Revision    : 1.0 - initial release
// ============================================================================
module sti_rx
  import sti_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        si_data,
  input  logic        si_valid,
  input  logic [1:0]  cfg_length,
  input  logic        cfg_msb,
  input  logic        si_end,
  input  logic        po_ready,
  output logic [31:0] po_data,
  output logic [1:0]  po_len,
  output logic        po_valid,
  output logic        frame_err,
  output logic        overflow,
  output logic        rx_finish
);

  rx_state_t         r_state;
  logic [5:0]        r_bit_cnt;   // bits still to come in the current frame
  logic [4:0]        r_bit_idx;   // LSB-first insert position of next bit
  logic [LEN_W-1:0]  r_len;
  logic              r_msb;
  logic [WORD_W-1:0] r_word;
  logic              r_end_flag;
  logic              r_frame_err;
  logic              r_overflow;
  logic              r_finish;

  logic              w_active;
  logic              w_first;
  logic              w_last;
  logic              w_msb_cur;
  logic [WORD_W-1:0] w_base;
  logic [4:0]        w_idx;
  logic [WORD_W-1:0] w_word_next;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [FIFO_W-1:0] w_rd_data;

  // --------------------------------------------------------------------------
  // Bit assembly. A "first" bit is one arriving in IDLE or right after a
  // completed frame (bit_cnt == 0 in RECV), which gives gap-free chaining.
  // --------------------------------------------------------------------------
  always_comb begin
    w_active    = si_valid && !r_finish;
    w_first     = w_active && ((r_state == ST_IDLE) || (r_bit_cnt == 6'd0));
    w_last      = w_active && !w_first && (r_bit_cnt == 6'd1);
    w_msb_cur   = w_first ? cfg_msb : r_msb;
    w_base      = w_first ? '0 : r_word;
    w_idx       = w_first ? 5'd0 : r_bit_idx;
    w_word_next = w_base;
    if (w_msb_cur) begin
      w_word_next = {w_base[WORD_W-2:0], si_data};
    end else begin
      w_word_next[w_idx] = si_data;
    end
  end

  // The completed word goes straight into the FIFO on the edge that samples
  // its last bit, so po_valid can rise on the next cycle.
  assign w_push = w_last;
  assign w_pop  = po_ready && !w_empty;

  sti_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data ({r_len, w_word_next}),
    .pop       (w_pop),
    .pop_data  (w_rd_data),
    .full      (w_full),
    .empty     (w_empty)
  );

  // --------------------------------------------------------------------------
  // Receiver FSM with registered status outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 6'd0;
      r_bit_idx   <= 5'd0;
      r_len       <= LEN_8;
      r_msb       <= 1'b0;
      r_word      <= '0;
      r_end_flag  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
      r_finish    <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overflow  <= w_push && w_full && !w_pop;

      if (r_end_flag && w_empty && (r_state == ST_IDLE)) begin
        r_finish <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_active) begin
            r_len     <= cfg_length;
            r_msb     <= cfg_msb;
            r_bit_cnt <= len_bits(cfg_length) - 6'd1;
            r_bit_idx <= 5'd1;
            r_word    <= w_word_next;
            r_state   <= ST_RECV;
          end
        end

        ST_RECV: begin
          if (!w_active) begin
            // Dropping si_valid mid-frame is a truncation; after the last
            // bit (bit_cnt == 0) it is a normal end of frame.
            if (r_bit_cnt != 6'd0) r_frame_err <= 1'b1;
            r_bit_cnt <= 6'd0;
            r_bit_idx <= 5'd0;
            r_word    <= '0;
            r_state   <= ST_IDLE;
          end else if (w_first) begin
            r_len     <= cfg_length;
            r_msb     <= cfg_msb;
            r_bit_cnt <= len_bits(cfg_length) - 6'd1;
            r_bit_idx <= 5'd1;
            r_word    <= w_word_next;
          end else begin
            r_word    <= w_word_next;
            r_bit_cnt <= r_bit_cnt - 6'd1;
            r_bit_idx <= r_bit_idx + 5'd1;
            if (w_last && si_end) r_end_flag <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Head of FIFO is held by the FIFO itself while stalled; force zero when
  // empty so the port reads 0 after reset.
  assign po_valid  = !w_empty;
  assign po_data   = w_empty ? '0 : w_rd_data[WORD_W-1:0];
  assign po_len    = w_empty ? '0 : w_rd_data[FIFO_W-1:WORD_W];
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;
  assign rx_finish = r_finish;

endmodule
`default_nettype wire

// File: doc/sti_rx.md
STI_RX -- requirements
Module: sti_rx

Interface
REQ-001 FIFO_DEPTH, 4, number of assembled words buffered between the receiver and the consumer; power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 si_data  input  1  serial data bit, sampled only while si_valid=1.
REQ-005 si_valid  input  1  bit-valid strobe; a frame is one contiguous run of si_valid=1 cycles.
REQ-006 cfg_length  input  2  frame length code: 0=8, 1=16, 2=24, 3=32 bits; sampled on the first bit of a frame.
REQ-007 cfg_msb  input  1  1=first bit is the word MSB, 0=first bit is the LSB; sampled on the first bit of a frame.
REQ-008 si_end  input  1  marks the current frame as the final frame; sampled on the last bit of a frame.
REQ-009 po_ready  input  1  consumer accepts po_data when po_valid=1 and po_ready=1.
REQ-010 po_data  output  32  assembled word, right-aligned, unused upper bits 0.
REQ-011 po_len  output  2  length code of the word on po_data.
REQ-012 po_valid  output  1  FIFO not empty.
REQ-013 frame_err  output  1  one-cycle pulse on a truncated frame.
REQ-014 overflow  output  1  one-cycle pulse when a completed word is dropped because the FIFO is full.
REQ-015 rx_finish  output  1  sticky; high once the final frame is accepted and the FIFO has drained.

Function
REQ-016 The FSM SHALL have states IDLE and RECV; IDLE->RECV on si_valid=1; RECV->IDLE on the last bit with si_valid low on the next cycle, or on truncation.
REQ-017 The first bit SHALL latch cfg_length/cfg_msb and load bit_cnt with N-1, where N=8*(cfg_length+1).
REQ-018 MSB-first: shift left, inserting at bit 0. LSB-first: the k-th received bit (k from 0) SHALL land at bit k.
REQ-019 On the edge that samples bit N, the word SHALL be written to the FIFO; po_valid SHALL rise the following cycle when the FIFO was empty.
REQ-020 If si_valid remains 1 after bit N, that cycle SHALL be bit 1 of a new frame, with config resampled and no gap required.
REQ-021 si_valid=0 while in RECV before bit N SHALL discard the partial word, pulse frame_err the next cycle, and return to IDLE.
REQ-022 A FIFO write while full SHALL drop the new word, pulse overflow, and leave the stored words intact; a simultaneous pop frees space, so the write succeeds.
REQ-023 si_end=1 on an accepted final bit SHALL set an end flag; rx_finish SHALL assert when end flag=1, FIFO empty and FSM in IDLE; further input is ignored once rx_finish=1.
REQ-024 po_data/po_len SHALL hold stable while po_valid=1 and po_ready=0.

Reset
REQ-025 Reset SHALL force IDLE, bit_cnt=0, an empty FIFO, end flag=0, po_data=0, po_len=0, po_valid=0, frame_err=0, overflow=0, rx_finish=0.
REQ-026 Reset mid-frame SHALL discard the partial word without pulsing frame_err.

Structure
REQ-027 Length codes, the function mapping a length code to N, and the FSM state enum SHALL live in shared package sti_pkg.
REQ-028 The FIFO SHALL be a sub-module sti_rx_fifo, 34 bits wide (data+len) and FIFO_DEPTH deep, with full/empty flags.

Verification
REQ-029 cfg_length=0, cfg_msb=1, bits 1,0,1,0,0,1,0,1 -> po_data=0x000000A5, po_len=0, po_valid one cycle after the 8th bit.
REQ-030 cfg_length=1, cfg_msb=0, 0x1234 sent LSB-first, then 0xBEEF back-to-back with si_valid held -> two words 0x1234, 0xBEEF, no frame_err.
REQ-031 cfg_length=3, si_valid drops after 20 bits -> frame_err pulse, FIFO unchanged, next 8-bit frame 0x3C received correctly.
REQ-032 po_ready=0, FIFO_DEPTH=4, five 8-bit frames 0x01..0x05 -> overflow pulses once at the 5th word; draining yields 0x01..0x04.
REQ-033 reset asserted after 5 bits of a 24-bit frame -> all outputs 0, no frame_err; subsequent 0xC0FFEE 24-bit frame received.
REQ-034 final 8-bit frame 0x7E with si_end=1, po_ready=1 -> word popped, rx_finish=1 the cycle after the FIFO empties and stays high.
